aes128_key_expand: RTL and testbench



---
 rtl/aes128_key_expand.sv | 131 +++++++++++++
 tb/tb_aes128_key_expand.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/aes128_key_expand.sv
// Sequential AES-128 key schedule: emits round keys 0..10 over a valid/ready stream,
// computing each next key combinationally from the current one with four S-box lookups.

module sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);
    localparam logic [7:0] SboxTable [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b,
        8'hfe, 8'hd7, 8'hab, 8'h76, 8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
        8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0, 8'hb7, 8'hfd, 8'h93, 8'h26,
        8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2,
        8'heb, 8'h27, 8'hb2, 8'h75, 8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
        8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84, 8'h53, 8'hd1, 8'h00, 8'hed,
        8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f,
        8'h50, 8'h3c, 8'h9f, 8'ha8, 8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
        8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2, 8'hcd, 8'h0c, 8'h13, 8'hec,
        8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14,
        8'hde, 8'h5e, 8'h0b, 8'hdb, 8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
        8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79, 8'he7, 8'hc8, 8'h37, 8'h6d,
        8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f,
        8'h4b, 8'hbd, 8'h8b, 8'h8a, 8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
        8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e, 8'he1, 8'hf8, 8'h98, 8'h11,
        8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f,
        8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign out_byte = SboxTable[in_byte];
endmodule

module aes128_key_expand (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic         busy,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk,
    output logic [3:0]   rk_idx,
    output logic         done
);
    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e       state_q, state_d;
    logic [127:0] key_q, key_d, key_next;
    logic [3:0]   idx_q, idx_d;
    logic [7:0]   rcon_q, rcon_d, rcon_next;
    logic         done_q, done_d;

    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  rot_w3, sub_w3, t;
    logic [31:0]  n0, n1, n2, n3;

    assign {w0, w1, w2, w3} = key_q;
    assign rot_w3 = {w3[23:0], w3[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        sbox u_sbox (
            .in_byte  (rot_w3[8*i +: 8]),
            .out_byte (sub_w3[8*i +: 8])
        );
    end

    // Chained XORs: each new word depends on the one just produced.
    assign t  = sub_w3 ^ {rcon_q, 24'h0};
    assign n0 = w0 ^ t;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;
    assign key_next  = {n0, n1, n2, n3};
    assign rcon_next = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        idx_d   = idx_q;
        rcon_d  = rcon_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    key_d   = key_in;
                    idx_d   = 4'd0;
                    rcon_d  = 8'h01;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (rk_ready) begin
                    if (idx_q == 4'd10) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end else begin
                        key_d  = key_next;
                        idx_d  = idx_q + 4'd1;
                        rcon_d = rcon_next;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            key_q   <= '0;
            idx_q   <= '0;
            rcon_q  <= 8'h01;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            idx_q   <= idx_d;
            rcon_q  <= rcon_d;
            done_q  <= done_d;
        end
    end

    assign busy     = (state_q == StRun);
    assign rk_valid = (state_q == StRun);
    assign rk       = key_q;
    assign rk_idx   = idx_q;
    assign done     = done_q;
endmodule

// File: tb/tb_aes128_key_expand.sv
// Directed bench for aes128_key_expand: FIPS-197 and zero-key schedules, stalls,
// ignored starts, mid-run reset and back-to-back runs.

module tb_aes128_key_expand;
    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] key_in;
    logic         busy;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] rk;
    logic [3:0]   rk_idx;
    logic         done;

    aes128_key_expand dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .key_in   (key_in),
        .busy     (busy),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .rk       (rk),
        .rk_idx   (rk_idx),
        .done     (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           run;
        int           idx;
        logic [127:0] exp_rk;
    } vec_t;

    localparam logic [127:0] KeyA = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    int           n_cmp = 0;
    int           n_err = 0;
    int           hs;
    int           dn;
    int           stall_bad;
    logic [127:0] res [4][11];
    logic [127:0] app_a [11];
    vec_t         vecs [$];

    function automatic void check(string name, logic [127:0] got, logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one full schedule, capturing each accepted key into res[run].
    task automatic run_keys(input int run, input logic [127:0] k, input int pct,
                            input bit poke_start, input int exp_done_cyc);
        int           cycles;
        int           done_cyc;
        bit           stalled;
        logic [127:0] s_rk;
        logic [3:0]   s_idx;
        hs = 0; dn = 0; stall_bad = 0; cycles = 0; stalled = 0; done_cyc = 0;
        s_rk = '0; s_idx = '0;
        start = 1'b1; key_in = k;
        step();
        start = 1'b0; key_in = ~k;
        check("first_cycle", 128'({busy, rk_valid, rk_idx}), 128'({1'b1, 1'b1, 4'd0}));
        while (cycles < 400 && dn == 0) begin
            if (rk_valid) begin
                if (stalled && (rk !== s_rk || rk_idx !== s_idx)) stall_bad++;
                rk_ready = (int'($urandom_range(99)) < pct);
                if (poke_start) start = (rk_idx == 4'd3) || (rk_idx == 4'd10 && rk_ready);
                if (rk_ready) begin
                    if (rk_idx <= 4'd10) res[run][rk_idx] = rk;
                    hs++;
                    stalled = 0;
                end else begin
                    stalled = 1; s_rk = rk; s_idx = rk_idx;
                end
            end
            step();
            start = 1'b0; rk_ready = 1'b0;
            cycles++;
            if (done) begin
                dn++;
                done_cyc = cycles + 1;
            end
        end
        check("handshakes", 128'(hs), 128'd11);
        check("done_seen", 128'(dn), 128'd1);
        check("stall_stable", 128'(stall_bad), 128'd0);
        check("idle_at_done", 128'({busy, rk_valid}), 128'd0);
        if (exp_done_cyc != 0) check("done_latency", 128'(done_cyc), 128'(exp_done_cyc));
    endtask

    initial begin
        int  guard;
        bit  bad;
        app_a[0]  = KeyA;
        app_a[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        app_a[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        app_a[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        app_a[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        app_a[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        app_a[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        app_a[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        app_a[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        app_a[9]  = 128'hac7766f319fadc2128d12941575c006e;
        app_a[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        // Runs 0, 2, 3 use the App. A key; run 1 uses the zero key.
        foreach (app_a[i]) begin
            vecs.push_back('{run: 0, idx: i, exp_rk: app_a[i]});
            vecs.push_back('{run: 2, idx: i, exp_rk: app_a[i]});
            vecs.push_back('{run: 3, idx: i, exp_rk: app_a[i]});
        end
        vecs.push_back('{run: 1, idx: 0,  exp_rk: 128'h0});
        vecs.push_back('{run: 1, idx: 1,  exp_rk: 128'h62636363626363636263636362636363});
        vecs.push_back('{run: 1, idx: 10, exp_rk: 128'hb4ef5bcb3e92e21123e951cf6f8f188e});
        foreach (res[r, i]) res[r][i] = '1;

        rst = 1'b1; start = 1'b0; key_in = '0; rk_ready = 1'b0;
        step();
        step();
        check("reset_state", {busy, rk_valid, done, rk_idx, rk[120:0]}, 128'd0);
        check("reset_rk", rk, 128'd0);
        rst = 1'b0;
        step();

        run_keys(0, KeyA, 100, 1'b0, 12);
        // Second start issued in the done cycle of the first run.
        run_keys(1, 128'd0, 100, 1'b0, 12);
        step();
        check("done_one_cycle", 128'({done, busy}), 128'd0);

        run_keys(2, KeyA, 30, 1'b1, 0);
        step();
        check("final_start_ignored", 128'({busy, rk_valid, done}), 128'd0);

        // Reset at rk_idx 5 with start also high.
        start = 1'b1; key_in = 128'hffff_0000_ffff_0000_ffff_0000_ffff_0000;
        step();
        start = 1'b0; rk_ready = 1'b1; guard = 0;
        while (rk_idx != 4'd5 && guard < 20) begin
            step();
            guard++;
        end
        check("reached_idx5", 128'(rk_idx), 128'd5);
        rst = 1'b1; start = 1'b1; rk_ready = 1'b0;
        step();
        rst = 1'b0; start = 1'b0;
        check("reset_midrun", {busy, rk_valid, done, rk_idx, rk[120:0]}, 128'd0);
        check("reset_midrun_rk", rk, 128'd0);
        bad = 0;
        for (int c = 0; c < 4; c++) begin
            step();
            if (done || busy) bad = 1;
        end
        check("no_done_after_reset", 128'(bad), 128'd0);
        run_keys(3, KeyA, 100, 1'b0, 12);

        foreach (vecs[v]) begin
            check($sformatf("run%0d_rk%0d", vecs[v].run, vecs[v].idx),
                  res[vecs[v].run][vecs[v].idx], vecs[v].exp_rk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
